wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 25 ++
 rtl/wb_arbiter_if.sv | 29 ++
 rtl/wb_arbiter_fifo.sv | 62 ++++++
 rtl/wb_arbiter.sv | 125 ++++++++++++
 tb/tb_wb_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types and defaults for the writeback arbiter.
package wb_arbiter_pkg;

  localparam int unsigned STARVE_MAX_DEF = 4;
  localparam int unsigned B_DEPTH_DEF    = 2;

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_FORCE_B = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } b_entry_t;

  // One-hot pending bit for a destination register; x0 never counts as pending.
  function automatic logic [31:0] rd_bit(input logic [4:0] rd);
    logic [31:0] m;
    m = '0;
    if (rd != '0) m[rd] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Request, regfile-write and bypass signals of the writeback arbiter.
interface wb_arbiter_if;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        b_ready;
  logic        regfile_w_en;
  logic [4:0]  regfile_w_reg;
  logic [31:0] regfile_w_data;
  logic [4:0]  wb_bp_reg;
  logic [31:0] wb_bp_val;
  logic [31:0] b_pending_mask;

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output a_ready, b_ready, regfile_w_en, regfile_w_reg, regfile_w_data,
           wb_bp_reg, wb_bp_val, b_pending_mask
  );

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  a_ready, b_ready, regfile_w_en, regfile_w_reg, regfile_w_data,
           wb_bp_reg, wb_bp_val, b_pending_mask
  );
endinterface

// File: rtl/wb_arbiter_fifo.sv
// Shift-register FIFO for long-latency results; head always sits in slot 0.
module wb_arb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = B_DEPTH_DEF,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  b_entry_t              din_i,
  output b_entry_t              head_o,
  output b_entry_t [DEPTH-1:0]  next_slots_o,
  output logic [CNT_W-1:0]      count_o,
  output logic [CNT_W-1:0]      next_count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  b_entry_t [DEPTH-1:0] slot_q, slot_d;
  logic [CNT_W-1:0]     count_q, count_d, wr_idx;
  logic                 push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  // A full FIFO refuses a push even when it pops in the same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign wr_idx  = count_q - CNT_W'(pop_ok);

  // Next contents: shift down on pop, then write the new entry behind the survivors.
  always_comb begin
    slot_d = slot_q;
    if (pop_ok) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) slot_d[i] = slot_q[i+1];
    end
    if (push_ok) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_idx == CNT_W'(i)) slot_d[i] = din_i;
      end
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q  <= '0;
      count_q <= '0;
    end else begin
      slot_q  <= slot_d;
      count_q <= count_d;
    end
  end

  assign head_o       = slot_q[0];
  assign next_slots_o = slot_d;
  assign count_o      = count_q;
  assign next_count_o = count_d;

endmodule

// File: rtl/wb_arbiter.sv
// Single-port regfile writeback arbiter: in-order pipeline (A) vs buffered long-latency results (B).
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
  parameter int unsigned B_DEPTH    = B_DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W      = $clog2(B_DEPTH + 1);
  localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX - 1);

  arb_state_e               state_q, state_d;
  logic [3:0]               starve_q, starve_d;
  logic                     grant_a, grant_b, a_rdy;
  b_entry_t                 head, grant_ent, b_in;
  b_entry_t [B_DEPTH-1:0]   nxt_slots;
  logic [CNT_W-1:0]         fifo_count, nxt_count;
  logic                     fifo_full, fifo_empty, fifo_push;
  logic                     w_en_q, w_en_d;
  logic [4:0]               w_reg_q, w_reg_d, bp_reg_q, bp_reg_d;
  logic [31:0]              w_data_q, w_data_d, bp_val_q, bp_val_d;
  logic [31:0]              mask_q, mask_d;

  assign b_in.rd   = bus.b_rd;
  assign b_in.data = bus.b_data;
  assign fifo_push = bus.b_valid && bus.b_ready;

  wb_arb_fifo #(.DEPTH(B_DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (fifo_push),
    .pop_i        (grant_b),
    .din_i        (b_in),
    .head_o       (head),
    .next_slots_o (nxt_slots),
    .count_o      (fifo_count),
    .next_count_o (nxt_count),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  assign bus.a_ready = a_rdy;
  assign bus.b_ready = !fifo_full && rst_n;

  // Grant selection and FSM next state; nothing is granted while in reset.
  always_comb begin
    state_d = state_q;
    a_rdy   = 1'b0;
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        ST_NORMAL: begin
          a_rdy = 1'b1;
          if (bus.a_valid)      grant_a = 1'b1;
          else if (!fifo_empty) grant_b = 1'b1;
          if (grant_a && !fifo_empty && starve_q == STARVE_LIM) state_d = ST_FORCE_B;
        end
        ST_FORCE_B: begin
          grant_b = !fifo_empty;
          state_d = ST_NORMAL;
        end
      endcase
    end
    starve_d = (fifo_count == '0 || grant_b) ? '0 : starve_q + 4'd1;
  end

  // Regfile write, bypass and pending-mask next values.
  always_comb begin
    grant_ent = grant_b ? head : b_entry_t'({bus.a_rd, bus.a_data});
    w_en_d    = 1'b0;
    w_reg_d   = w_reg_q;
    w_data_d  = w_data_q;
    bp_reg_d  = bp_reg_q;
    bp_val_d  = bp_val_q;
    if (grant_a || grant_b) begin
      w_reg_d  = grant_ent.rd;
      w_data_d = grant_ent.data;
      w_en_d   = (grant_ent.rd != '0);
    end
    if (w_en_d) begin
      bp_reg_d = grant_ent.rd;
      bp_val_d = grant_ent.data;
    end
    mask_d = '0;
    for (int unsigned i = 0; i < B_DEPTH; i++) begin
      if (CNT_W'(i) < nxt_count) mask_d = mask_d | rd_bit(nxt_slots[i].rd);
    end
  end

  // State, starvation counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_NORMAL;
      starve_q <= '0;
      w_en_q   <= 1'b0;
      w_reg_q  <= '0;
      w_data_q <= '0;
      bp_reg_q <= '0;
      bp_val_q <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      w_en_q   <= w_en_d;
      w_reg_q  <= w_reg_d;
      w_data_q <= w_data_d;
      bp_reg_q <= bp_reg_d;
      bp_val_q <= bp_val_d;
      mask_q   <= mask_d;
    end
  end

  assign bus.regfile_w_en   = w_en_q;
  assign bus.regfile_w_reg  = w_reg_q;
  assign bus.regfile_w_data = w_data_q;
  assign bus.wb_bp_reg      = bp_reg_q;
  assign bus.wb_bp_val      = bp_val_q;
  assign bus.b_pending_mask = mask_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter against a queue-based behavioural model.
module tb_wb_arbiter;

  localparam int unsigned STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if bus();

  wb_arbiter #(.STARVE_MAX(STARVE_MAX), .B_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  int          waited;
  bit          forced;
  logic        m_wen, m_aready, m_bready, obs_aready, obs_bready;
  logic [4:0]  m_wreg, m_bpreg;
  logic [31:0] m_wdata, m_bpval, m_mask;

  // One clock: sample ready outputs, advance the model by the arbitration rules, cross the edge.
  task automatic step();
    ent_t g;
    bit   a_won, b_won;
    int   sz0;
    #1;
    obs_aready = bus.a_ready;
    obs_bready = bus.b_ready;
    if (!rst_n) begin
      m_aready = 0; m_bready = 0;
      q.delete(); waited = 0; forced = 0;
      m_wen = 0; m_wreg = 0; m_wdata = 0; m_bpreg = 0; m_bpval = 0; m_mask = 0;
    end else begin
      m_aready = !forced;
      m_bready = (q.size() < 2);
      sz0 = q.size();
      a_won = 0; b_won = 0;
      if ((forced || !bus.a_valid) && sz0 > 0) begin
        g = q.pop_front(); b_won = 1;
      end else if (!forced && bus.a_valid) begin
        g.rd = bus.a_rd; g.data = bus.a_data; a_won = 1;
      end
      m_wen = 0;
      if (a_won || b_won) begin
        m_wreg = g.rd; m_wdata = g.data; m_wen = (g.rd != 0);
        if (m_wen) begin m_bpreg = g.rd; m_bpval = g.data; end
      end
      forced = !forced && a_won && sz0 > 0 && waited == STARVE_MAX - 1;
      if (b_won || sz0 == 0) waited = 0; else waited++;
      if (bus.b_valid && m_bready) begin
        g.rd = bus.b_rd; g.data = bus.b_data; q.push_back(g);
      end
      m_mask = 0;
      foreach (q[i]) if (q[i].rd != 0) m_mask[q[i].rd] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    step(); step();
    n_checks++; if (obs_aready !== 1'b0) begin n_fail++; $display("FAIL reset a_ready: got %0b want 0", obs_aready); end
    n_checks++; if (obs_bready !== 1'b0) begin n_fail++; $display("FAIL reset b_ready: got %0b want 0", obs_bready); end
    n_checks++; if (bus.regfile_w_en !== 1'b0 || bus.regfile_w_reg !== 5'd0 || bus.regfile_w_data !== 32'd0)
      begin n_fail++; $display("FAIL reset w_*: got %0b/%0d/%h want 0", bus.regfile_w_en, bus.regfile_w_reg, bus.regfile_w_data); end
    n_checks++; if (bus.wb_bp_reg !== 5'd0 || bus.wb_bp_val !== 32'd0 || bus.b_pending_mask !== 32'd0)
      begin n_fail++; $display("FAIL reset bp/mask: got %0d/%h/%h want 0", bus.wb_bp_reg, bus.wb_bp_val, bus.b_pending_mask); end
    rst_n = 1;
  endtask

  task automatic test_a_only();
    bus.a_valid = 1; bus.a_rd = 5'd5; bus.a_data = 32'hDEADBEEF; bus.b_valid = 0;
    step();
    n_checks++; if (obs_aready !== 1'b1) begin n_fail++; $display("FAIL a_only a_ready: got %0b want 1", obs_aready); end
    n_checks++; if (bus.regfile_w_en !== 1'b1) begin n_fail++; $display("FAIL a_only w_en: got %0b want 1", bus.regfile_w_en); end
    n_checks++; if (bus.regfile_w_reg !== 5'd5) begin n_fail++; $display("FAIL a_only w_reg: got %0d want 5", bus.regfile_w_reg); end
    n_checks++; if (bus.regfile_w_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL a_only w_data: got %h want deadbeef", bus.regfile_w_data); end
    n_checks++; if (bus.wb_bp_reg !== 5'd5 || bus.wb_bp_val !== 32'hDEADBEEF)
      begin n_fail++; $display("FAIL a_only bp: got %0d/%h want 5/deadbeef", bus.wb_bp_reg, bus.wb_bp_val); end
    bus.a_valid = 0;
  endtask

  task automatic test_b_only();
    bus.b_valid = 1; bus.b_rd = 5'd7; bus.b_data = 32'h12;
    step();
    n_checks++; if (bus.b_pending_mask !== 32'h80) begin n_fail++; $display("FAIL b_only mask_after_push: got %h want 00000080", bus.b_pending_mask); end
    n_checks++; if (bus.regfile_w_en !== 1'b0) begin n_fail++; $display("FAIL b_only no_passthrough: got w_en %0b want 0", bus.regfile_w_en); end
    bus.b_valid = 0;
    step();
    n_checks++; if (bus.regfile_w_en !== 1'b1 || bus.regfile_w_reg !== 5'd7 || bus.regfile_w_data !== 32'h12)
      begin n_fail++; $display("FAIL b_only write: got %0b/%0d/%h want 1/7/12", bus.regfile_w_en, bus.regfile_w_reg, bus.regfile_w_data); end
    n_checks++; if (bus.b_pending_mask !== 32'h0) begin n_fail++; $display("FAIL b_only mask_after_pop: got %h want 0", bus.b_pending_mask); end
  endtask

  task automatic test_x0();
    bus.a_valid = 1; bus.a_rd = 5'd0; bus.a_data = 32'hFFFF;
    step();
    n_checks++; if (bus.regfile_w_en !== 1'b0 || bus.regfile_w_reg !== 5'd0 || bus.regfile_w_data !== 32'hFFFF)
      begin n_fail++; $display("FAIL x0 write: got %0b/%0d/%h want 0/0/ffff", bus.regfile_w_en, bus.regfile_w_reg, bus.regfile_w_data); end
    n_checks++; if (bus.wb_bp_reg !== 5'd7 || bus.wb_bp_val !== 32'h12)
      begin n_fail++; $display("FAIL x0 bp_hold: got %0d/%h want 7/12", bus.wb_bp_reg, bus.wb_bp_val); end
  endtask

  task automatic test_starvation();
    bus.a_valid = 1; bus.a_rd = 5'($urandom_range(1, 31)); bus.a_data = $urandom;
    bus.b_valid = 1; bus.b_rd = 5'd3; bus.b_data = 32'h33;
    step();
    bus.b_valid = 0;
    for (int i = 0; i < 4; i++) begin
      bus.a_rd = 5'($urandom_range(1, 31)); bus.a_data = $urandom;
      step();
      n_checks++; if (obs_aready !== 1'b1 || bus.regfile_w_reg !== bus.a_rd || bus.regfile_w_data !== bus.a_data)
        begin n_fail++; $display("FAIL starve a_phase%0d: got rdy %0b reg %0d want 1/%0d", i, obs_aready, bus.regfile_w_reg, bus.a_rd); end
    end
    step();
    n_checks++; if (obs_aready !== 1'b0) begin n_fail++; $display("FAIL starve force_a_ready: got %0b want 0", obs_aready); end
    n_checks++; if (bus.regfile_w_en !== 1'b1 || bus.regfile_w_reg !== 5'd3 || bus.regfile_w_data !== 32'h33)
      begin n_fail++; $display("FAIL starve b_write: got %0b/%0d/%h want 1/3/33", bus.regfile_w_en, bus.regfile_w_reg, bus.regfile_w_data); end
    step();
    n_checks++; if (obs_aready !== 1'b1 || bus.regfile_w_reg !== bus.a_rd)
      begin n_fail++; $display("FAIL starve resume: got rdy %0b reg %0d want 1/%0d", obs_aready, bus.regfile_w_reg, bus.a_rd); end
  endtask

  task automatic test_full();
    bit accepted = 0;
    bus.a_valid = 1; bus.a_rd = 5'd1; bus.a_data = 32'h1;
    bus.b_valid = 1; bus.b_rd = 5'd10; bus.b_data = 32'hA;
    step();
    bus.b_rd = 5'd11; bus.b_data = 32'hB;
    step();
    n_checks++; if (obs_bready !== 1'b1) begin n_fail++; $display("FAIL full second_push_ready: got %0b want 1", obs_bready); end
    bus.b_rd = 5'd12; bus.b_data = 32'hC;
    step();
    n_checks++; if (obs_bready !== 1'b0) begin n_fail++; $display("FAIL full b_ready: got %0b want 0", obs_bready); end
    n_checks++; if (bus.b_pending_mask !== 32'h0C00) begin n_fail++; $display("FAIL full mask: got %h want 00000c00", bus.b_pending_mask); end
    for (int i = 0; i < 10 && !accepted; i++) begin
      step();
      n_checks++; if (obs_bready !== m_bready) begin n_fail++; $display("FAIL full wait_ready%0d: got %0b want %0b", i, obs_bready, m_bready); end
      n_checks++; if (bus.b_pending_mask !== m_mask) begin n_fail++; $display("FAIL full wait_mask%0d: got %h want %h", i, bus.b_pending_mask, m_mask); end
      accepted = m_mask[12];
    end
    n_checks++; if (!accepted) begin n_fail++; $display("FAIL full held_push: got never accepted want accepted within 10 cycles"); end
    bus.b_valid = 0;
  endtask

  task automatic test_reset_midop();
    bus.a_valid = 1; bus.b_valid = 1;
    for (int i = 0; i < 8 && q.size() < 2; i++) begin
      bus.b_rd = 5'($urandom_range(1, 31)); step();
    end
    n_checks++; if (bus.b_pending_mask !== m_mask || q.size() != 2)
      begin n_fail++; $display("FAIL midop prefill: got mask %h depth %0d want %h/2", bus.b_pending_mask, q.size(), m_mask); end
    rst_n = 0; bus.a_valid = 0; bus.b_valid = 0;
    step();
    n_checks++; if (bus.b_pending_mask !== 32'h0 || bus.regfile_w_en !== 1'b0)
      begin n_fail++; $display("FAIL midop reset: got mask %h w_en %0b want 0/0", bus.b_pending_mask, bus.regfile_w_en); end
    n_checks++; if (obs_aready !== 1'b0 || obs_bready !== 1'b0)
      begin n_fail++; $display("FAIL midop ready_in_reset: got %0b/%0b want 0/0", obs_aready, obs_bready); end
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (bus.regfile_w_en !== 1'b0 || bus.b_pending_mask !== 32'h0)
        begin n_fail++; $display("FAIL midop after_release%0d: got w_en %0b mask %h want 0/0", i, bus.regfile_w_en, bus.b_pending_mask); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n        = ($urandom_range(0, 49) != 0);
      bus.a_valid  = ($urandom_range(0, 2) != 0);
      bus.a_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      bus.a_data   = $urandom;
      bus.b_valid  = $urandom_range(0, 1);
      bus.b_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 6));
      bus.b_data   = $urandom;
      step();
      n_checks++; if (obs_aready !== m_aready) begin n_fail++; $display("FAIL rand%0d a_ready: got %0b want %0b", i, obs_aready, m_aready); end
      n_checks++; if (obs_bready !== m_bready) begin n_fail++; $display("FAIL rand%0d b_ready: got %0b want %0b", i, obs_bready, m_bready); end
      n_checks++; if (bus.regfile_w_en !== m_wen) begin n_fail++; $display("FAIL rand%0d w_en: got %0b want %0b", i, bus.regfile_w_en, m_wen); end
      n_checks++; if (bus.regfile_w_reg !== m_wreg) begin n_fail++; $display("FAIL rand%0d w_reg: got %0d want %0d", i, bus.regfile_w_reg, m_wreg); end
      n_checks++; if (bus.regfile_w_data !== m_wdata) begin n_fail++; $display("FAIL rand%0d w_data: got %h want %h", i, bus.regfile_w_data, m_wdata); end
      n_checks++; if (bus.wb_bp_reg !== m_bpreg) begin n_fail++; $display("FAIL rand%0d bp_reg: got %0d want %0d", i, bus.wb_bp_reg, m_bpreg); end
      n_checks++; if (bus.wb_bp_val !== m_bpval) begin n_fail++; $display("FAIL rand%0d bp_val: got %h want %h", i, bus.wb_bp_val, m_bpval); end
      n_checks++; if (bus.b_pending_mask !== m_mask) begin n_fail++; $display("FAIL rand%0d mask: got %h want %h", i, bus.b_pending_mask, m_mask); end
    end
    rst_n = 1;
  endtask

  initial begin
    bus.a_valid = 0; bus.a_rd = '0; bus.a_data = '0;
    bus.b_valid = 0; bus.b_rd = '0; bus.b_data = '0;
    waited = 0; forced = 0;
    test_reset();
    test_a_only();
    test_b_only();
    test_x0();
    test_starvation();
    test_full();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
